// File: rtl/volt_msg_tx_if.sv
// volt_msg_tx_if: byte stream handshake from the frame serialiser to the UART
// transmitter.
//   tx_data  - current frame byte
//   tx_valid - tx_data holds a byte waiting to be taken
//   tx_ready - the sink takes the byte on a cycle where tx_valid is also high
// master = serialiser side, slave = UART side.
interface volt_msg_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/volt_msg_tx.sv
// volt_msg_tx: periodically snapshots both channels' BCD millivolt readings and
// sign characters, then sends them as the 25-byte text frame
// "CH1:+4.998V CH2:-0.012V\r\n" over a byte valid/ready handshake.
// Ports:
//   ad_clk, rst          - clock (rising edge), asynchronous active-high reset
//   enable               - periodic framing active
//   ch1_dec, ch2_dec     - 5-digit BCD values in mV, [19:16] most significant
//   ch1_sig, ch2_sig     - ASCII '+' / '-'
//   tx                   - byte handshake (master side)
//   busy                 - frame in progress (SEND or DONE)
//   frame_done           - one-cycle pulse after the last byte is taken
//   ovr_flag             - sticky, a snapshot had a nonzero ten-thousands digit
//   drop_cnt             - saturating count of ticks that arrived while busy
//
// state | meaning
// IDLE  | waiting for a period tick
// SEND  | presenting frame byte idx_q until the sink takes it
// DONE  | one cycle after the final byte, frame_done high
module volt_msg_tx #(
    parameter int unsigned PERIOD_CYCLES = 25000000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                ad_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [19:0]         ch1_dec,
    input  logic [19:0]         ch2_dec,
    input  logic [7:0]          ch1_sig,
    input  logic [7:0]          ch2_sig,
    volt_msg_tx_if.master       tx,
    output logic                busy,
    output logic                frame_done,
    output logic                ovr_flag,
    output logic [7:0]          drop_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [4:0]       IDX_LAST = 5'd24;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        idx_q, idx_d;
    logic [19:0]       s1_dec_q, s1_dec_d, s2_dec_q, s2_dec_d;
    logic [7:0]        s1_sig_q, s1_sig_d, s2_sig_q, s2_sig_d;
    logic              ovr_q, ovr_d;
    logic [7:0]        drop_q, drop_d;

    logic              tick;
    logic              start;
    logic              xfer;
    logic [7:0]        frame_byte;

    function automatic logic [7:0] digit_chr(input logic [3:0] d, input logic ovr);
        if (ovr)
            return 8'h39;
        else if (d <= 4'd9)
            return 8'h30 + {4'd0, d};
        else
            return 8'h3F;
    endfunction

    function automatic logic [7:0] sign_chr(input logic [7:0] s);
        if (s == 8'h2B || s == 8'h2D)
            return s;
        else
            return 8'h3F;
    endfunction

    assign tick  = enable && (cnt_q == CNT_LAST);
    assign start = (state_q == IDLE) && tick;
    assign xfer  = (state_q == SEND) && tx.tx_ready;

    // State register
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = SEND;
            SEND:    if (xfer && idx_q == IDX_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        tx.tx_valid = (state_q == SEND);
        tx.tx_data  = (state_q == SEND) ? frame_byte : 8'h00;
        busy        = (state_q != IDLE);
        frame_done  = (state_q == DONE);
        ovr_flag    = ovr_q;
        drop_cnt    = drop_q;
    end

    // Datapath registers
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            s1_dec_q <= '0;
            s2_dec_q <= '0;
            s1_sig_q <= '0;
            s2_sig_q <= '0;
            ovr_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            s1_dec_q <= s1_dec_d;
            s2_dec_q <= s2_dec_d;
            s1_sig_q <= s1_sig_d;
            s2_sig_q <= s2_sig_d;
            ovr_q    <= ovr_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        cnt_d    = '0;
        idx_d    = idx_q;
        s1_dec_d = s1_dec_q;
        s2_dec_d = s2_dec_q;
        s1_sig_d = s1_sig_q;
        s2_sig_d = s2_sig_q;
        ovr_d    = ovr_q;
        drop_d   = drop_q;

        if (enable)
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

        if (start) begin
            s1_dec_d = ch1_dec;
            s2_dec_d = ch2_dec;
            s1_sig_d = ch1_sig;
            s2_sig_d = ch2_sig;
            idx_d    = '0;
            if (ch1_dec[19:16] != 4'd0 || ch2_dec[19:16] != 4'd0)
                ovr_d = 1'b1;
        end else if (xfer && idx_q != IDX_LAST) begin
            idx_d = idx_q + 5'd1;
        end

        // Ticks landing mid-frame are counted, never restart the frame.
        if (tick && state_q != IDLE && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    // Byte mux: both channel fields share one layout; bytes 12..24 reuse the
    // channel-1 positions offset by 12, with CR/LF replacing the trailing space.
    always_comb begin
        logic        ch2;
        logic [4:0]  pos;
        logic [19:0] dec;
        logic [7:0]  sig;
        logic        ovr;

        ch2 = (idx_q >= 5'd12);
        pos = ch2 ? idx_q - 5'd12 : idx_q;
        dec = ch2 ? s2_dec_q : s1_dec_q;
        sig = ch2 ? s2_sig_q : s1_sig_q;
        ovr = (dec[19:16] != 4'd0);

        case (pos)
            5'd0:    frame_byte = 8'h43;
            5'd1:    frame_byte = 8'h48;
            5'd2:    frame_byte = ch2 ? 8'h32 : 8'h31;
            5'd3:    frame_byte = 8'h3A;
            5'd4:    frame_byte = sign_chr(sig);
            5'd5:    frame_byte = digit_chr(dec[15:12], ovr);
            5'd6:    frame_byte = 8'h2E;
            5'd7:    frame_byte = digit_chr(dec[11:8], ovr);
            5'd8:    frame_byte = digit_chr(dec[7:4], ovr);
            5'd9:    frame_byte = digit_chr(dec[3:0], ovr);
            5'd10:   frame_byte = 8'h56;
            5'd11:   frame_byte = ch2 ? 8'h0D : 8'h20;
            5'd12:   frame_byte = 8'h0A;
            default: frame_byte = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_volt_msg_tx.sv
// tb_volt_msg_tx: self-checking bench for volt_msg_tx.
// dut_a (period 40) covers the frame contents, handshake, snapshot, reset and
// enable behaviour; dut_b (period 10) covers dropped ticks and saturation.
module tb_volt_msg_tx;

    logic ad_clk = 1'b0;
    always #5 ad_clk = ~ad_clk;

    logic        rst, enable_a, enable_b, rdy_a, rdy_b;
    logic [19:0] ch1_dec, ch2_dec;
    logic [7:0]  ch1_sig, ch2_sig;
    logic        busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;
    logic [7:0]  drop_a, drop_b;

    volt_msg_tx_if ifa();
    volt_msg_tx_if ifb();
    assign ifa.tx_ready = rdy_a;
    assign ifb.tx_ready = rdy_b;

    volt_msg_tx #(.PERIOD_CYCLES(40), .CNT_W(8)) dut_a (
        .ad_clk(ad_clk), .rst(rst), .enable(enable_a),
        .ch1_dec(ch1_dec), .ch2_dec(ch2_dec), .ch1_sig(ch1_sig), .ch2_sig(ch2_sig),
        .tx(ifa), .busy(busy_a), .frame_done(done_a), .ovr_flag(ovr_a), .drop_cnt(drop_a)
    );

    volt_msg_tx #(.PERIOD_CYCLES(10), .CNT_W(4)) dut_b (
        .ad_clk(ad_clk), .rst(rst), .enable(enable_b),
        .ch1_dec(ch1_dec), .ch2_dec(ch2_dec), .ch1_sig(ch1_sig), .ch2_sig(ch2_sig),
        .tx(ifb), .busy(busy_b), .frame_done(done_b), .ovr_flag(ovr_b), .drop_cnt(drop_b)
    );

    bit          use_b = 1'b0;
    logic        m_valid, m_busy, m_done;
    logic [7:0]  m_data;
    assign m_valid = use_b ? ifb.tx_valid : ifa.tx_valid;
    assign m_data  = use_b ? ifb.tx_data  : ifa.tx_data;
    assign m_busy  = use_b ? busy_b : busy_a;
    assign m_done  = use_b ? done_b : done_a;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [19:0] d1;
        logic [7:0]  s1;
        logic [19:0] d2;
        logic [7:0]  s2;
        int          rp;
        string       exp;
        bit          exp_ovr;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_ready(input bit r);
        if (use_b) rdy_b = r;
        else       rdy_a = r;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Reference: one channel field, straight from the frame text rules.
    task automatic model_ch(input string tag, input logic [19:0] d, input logic [7:0] s,
                            input string tail);
        push_str(tag);
        exp_q.push_back((s == 8'd43 || s == 8'd45) ? s : 8'h3F);
        for (int n = 3; n >= 0; n--) begin
            int v;
            v = (int'(d) / (1 << (4 * n))) % 16;
            if (d >= 20'h10000) exp_q.push_back(8'h39);
            else if (v < 10)    exp_q.push_back(8'(48 + v));
            else                exp_q.push_back(8'h3F);
            if (n == 3) exp_q.push_back(8'h2E);
        end
        push_str(tail);
    endtask

    task automatic model_frame(input logic [19:0] d1, input logic [7:0] s1,
                               input logic [19:0] d2, input logic [7:0] s2);
        exp_q.delete();
        model_ch("CH1:", d1, s1, "V ");
        model_ch("CH2:", d2, s2, "V\r\n");
    endtask

    task automatic set_inputs(input logic [19:0] d1, input logic [7:0] s1,
                              input logic [19:0] d2, input logic [7:0] s2);
        ch1_dec = d1; ch1_sig = s1; ch2_dec = d2; ch2_sig = s2;
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    // Receive one frame. rp: 1 = always ready, 0 = random, N>1 = ready 1-of-N.
    // When chg_idx bytes have been taken, ch1_dec is overwritten with chg_val.
    // Called and returns at a falling edge; on return the DUT is idle again.
    task automatic get_frame(input int rp, input int chg_idx, input logic [19:0] chg_val,
                             input int budget);
        int         c;
        bit         hold, seen, r;
        logic [7:0] held;
        got_q.delete();
        hold = 0; seen = 0; held = '0;
        for (int i = 0; i < budget; i++) begin
            if (m_valid) begin seen = 1; break; end
            @(negedge ad_clk);
        end
        if (!seen) begin
            chk("start_timeout", {31'd0, m_valid}, 32'd1);
            return;
        end
        c = 0;
        while (got_q.size() < 25 && c < budget) begin
            if (chg_idx >= 0 && got_q.size() == chg_idx) ch1_dec = chg_val;
            if (hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", m_data, held);
            end
            if (!m_valid) begin
                chk("valid_gap", {31'd0, m_valid}, 32'd1);
                break;
            end
            if (rp == 1)      r = 1;
            else if (rp == 0) r = ($urandom_range(0, 1) == 1);
            else              r = ((c % rp) == rp - 1);
            set_ready(r);
            if (r) begin got_q.push_back(m_data); hold = 0; end
            else   begin hold = 1; held = m_data; end
            c++;
            @(negedge ad_clk);
        end
        set_ready(0);
        if (rp == 1) chk("valid_run_cycles", c, 32'd25);
        chk("end_valid_low", {31'd0, m_valid}, 32'd0);
        chk("done_pulse", {31'd0, m_done}, 32'd1);
        chk("done_busy", {31'd0, m_busy}, 32'd1);
        @(negedge ad_clk);
        chk("done_cleared", {31'd0, m_done}, 32'd0);
        chk("idle_busy", {31'd0, m_busy}, 32'd0);
    endtask

    task automatic set_vec(input int i, input logic [19:0] d1, input logic [7:0] s1,
                           input logic [19:0] d2, input logic [7:0] s2, input int rp,
                           input string exp, input bit ovr);
        vecs[i].d1 = d1; vecs[i].s1 = s1; vecs[i].d2 = d2; vecs[i].s2 = s2;
        vecs[i].rp = rp; vecs[i].exp = exp; vecs[i].exp_ovr = ovr;
    endtask

    function automatic logic [19:0] rand_dec();
        logic [19:0] d;
        d = '0;
        for (int n = 0; n < 5; n++) begin
            int v;
            v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                            : int'($urandom_range(0, 9));
            d[4*n +: 4] = v[3:0];
        end
        if ($urandom_range(0, 3) != 0) d[19:16] = 4'd0;
        return d;
    endfunction

    function automatic logic [7:0] rand_sig();
        int k;
        k = int'($urandom_range(0, 4));
        if (k < 2)      return 8'h2B;
        else if (k < 4) return 8'h2D;
        else            return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] d1, d2;
        logic [7:0]  s1, s2;
        int          n, first, seen_valid;

        set_vec(0, 20'h04998, 8'h2B, 20'h00012, 8'h2D, 1, "CH1:+4.998V CH2:-0.012V\r\n", 0);
        set_vec(1, 20'h04998, 8'h2B, 20'h00012, 8'h2D, 3, "CH1:+4.998V CH2:-0.012V\r\n", 0);
        set_vec(2, 20'h01234, 8'h00, 20'h00A00, 8'h2B, 1, "CH1:?1.234V CH2:+0.?00V\r\n", 0);
        set_vec(3, 20'h10000, 8'h2B, 20'h00012, 8'h2D, 2, "CH1:+9.999V CH2:-0.012V\r\n", 1);
        set_vec(4, 20'h09999, 8'h2D, 20'h00000, 8'h2B, 1, "CH1:-9.999V CH2:+0.000V\r\n", 1);
        set_vec(5, 20'h1F3A5, 8'h2B, 20'h0BCDE, 8'h2D, 3, "CH1:+9.999V CH2:-?.???V\r\n", 1);

        rst = 1'b1; enable_a = 1'b1; enable_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        set_inputs(vecs[0].d1, vecs[0].s1, vecs[0].d2, vecs[0].s2);
        repeat (3) @(negedge ad_clk);
        chk("rst_valid", {31'd0, ifa.tx_valid}, 32'd0);
        chk("rst_data", ifa.tx_data, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_a}, 32'd0);
        chk("rst_drop", drop_a, 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            set_inputs(vecs[i].d1, vecs[i].s1, vecs[i].d2, vecs[i].s2);
            exp_q.delete();
            push_str(vecs[i].exp);
            get_frame(vecs[i].rp, -1, 20'h0, 300);
            cmp_frame($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ovr", i), {31'd0, ovr_a}, {31'd0, vecs[i].exp_ovr});
        end

        // Input change mid-frame: snapshot holds, next frame picks it up
        set_inputs(20'h04998, 8'h2B, 20'h00012, 8'h2D);
        model_frame(20'h04998, 8'h2B, 20'h00012, 8'h2D);
        get_frame(1, 3, 20'h01111, 300);
        cmp_frame("snap_old");
        model_frame(20'h01111, 8'h2B, 20'h00012, 8'h2D);
        get_frame(1, -1, 20'h0, 300);
        cmp_frame("snap_new");

        // Randomized frames against the reference
        for (int r = 0; r < 8; r++) begin
            d1 = rand_dec(); d2 = rand_dec(); s1 = rand_sig(); s2 = rand_sig();
            set_inputs(d1, s1, d2, s2);
            model_frame(d1, s1, d2, s2);
            get_frame(0, -1, 20'h0, 400);
            cmp_frame($sformatf("rand%0d", r));
            chk("rand_ovr_sticky", {31'd0, ovr_a}, 32'd1);
        end

        // Reset in the middle of a frame, at byte index 10
        set_inputs(20'h04998, 8'h2B, 20'h00012, 8'h2D);
        n = 0;
        while (!ifa.tx_valid && n < 100) begin @(negedge ad_clk); n++; end
        chk("pre_rst_start", {31'd0, ifa.tx_valid}, 32'd1);
        rdy_a = 1'b1;
        repeat (10) @(negedge ad_clk);
        chk("byte10", ifa.tx_data, 32'h56);
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, ifa.tx_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_data", ifa.tx_data, 32'd0);
        chk("midrst_ovr", {31'd0, ovr_a}, 32'd0);
        chk("midrst_drop", drop_a, 32'd0);
        @(negedge ad_clk);
        rst = 1'b0;
        rdy_a = 1'b0;
        first = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge ad_clk);
            if (ifa.tx_valid) begin first = k; break; end
        end
        chk("restart_latency", first, 32'd40);
        model_frame(20'h04998, 8'h2B, 20'h00012, 8'h2D);
        get_frame(1, -1, 20'h0, 300);
        cmp_frame("after_rst");
        chk("after_rst_ovr", {31'd0, ovr_a}, 32'd0);

        // Enable dropped mid-frame: frame completes, then nothing more
        n = 0;
        while (!ifa.tx_valid && n < 100) begin @(negedge ad_clk); n++; end
        enable_a = 1'b0;
        get_frame(1, -1, 20'h0, 300);
        cmp_frame("en_low_frame");
        seen_valid = 0;
        repeat (120) begin
            @(negedge ad_clk);
            if (ifa.tx_valid) seen_valid++;
        end
        chk("disabled_no_frames", seen_valid, 32'd0);

        // dut_b, period 10: stall 50 cycles, count drops, then saturate
        use_b = 1'b1;
        set_inputs(20'h04998, 8'h2B, 20'h00012, 8'h2D);
        enable_b = 1'b1;
        n = 0;
        while (!ifb.tx_valid && n < 30) begin @(negedge ad_clk); n++; end
        chk("b_first_latency", n, 32'd10);
        rdy_b = 1'b0;
        repeat (50) @(negedge ad_clk);
        chk("b_stall_valid", {31'd0, ifb.tx_valid}, 32'd1);
        chk("b_stall_data", ifb.tx_data, 32'h43);
        // ticks at cycles 20..60 fell inside the stalled frame
        chk("b_drop_stall", drop_b, 32'd5);
        model_frame(20'h04998, 8'h2B, 20'h00012, 8'h2D);
        get_frame(1, -1, 20'h0, 300);
        cmp_frame("b_stalled_frame");
        // frame ran from cycle 10 to 86: ticks 20..80 dropped
        chk("b_drop_total", drop_b, 32'd7);
        // next frame starts at cycle 90 and stalls; each later tick is dropped
        repeat (2474) @(negedge ad_clk);
        chk("b_drop_254", drop_b, 32'd254);
        repeat (200) @(negedge ad_clk);
        chk("b_drop_sat", drop_b, 32'd255);
        get_frame(1, -1, 20'h0, 300);
        cmp_frame("b_sat_frame");
        chk("b_drop_sat_hold", drop_b, 32'd255);
        chk("b_ovr", {31'd0, ovr_b}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/volt_msg_tx.md
Name: volt_msg_tx

Overview:
- Downstream consumer of the voltage-calculation stage: takes both channels' BCD millivolt values and ASCII sign characters and serialises them into a fixed 25-byte text frame.
- Frame format: "CH1:+4.998V CH2:-0.012V\r\n".
- Frames go out over a byte valid/ready handshake into the UART transmitter.
- A frame is started periodically from an internal tick; inputs are snapshotted at frame start so one frame is internally consistent.

Parameters:
- PERIOD_CYCLES, 25000000, ad_clk cycles between frame start attempts (minimum 2).
- CNT_W, 32, width of the period counter; must hold PERIOD_CYCLES-1.

Ports:
- ad_clk  input  1  system/ADC clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  high = periodic framing active.
- ch1_dec  input  20  channel 1 BCD, 5 digits, [19:16] most significant, value in mV.
- ch2_dec  input  20  channel 2 BCD, same format.
- ch1_sig  input  8  channel 1 sign, ASCII '+' (43) or '-' (45).
- ch2_sig  input  8  channel 2 sign, same format.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts the byte this cycle.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last byte is accepted.
- ovr_flag  output  1  sticky, set if either snapshot had a nonzero ten-thousands digit.
- drop_cnt  output  8  saturating count of ticks dropped while busy.

Behaviour:
- Reset (async, rst high): tx_data=0, tx_valid=0, busy=0, frame_done=0, ovr_flag=0, drop_cnt=0, period counter=0, state=IDLE, byte index=0. Outputs clear immediately, including mid-frame. The frame is abandoned; there is no resume after release.
- Period counter:
  - enable high: increments each cycle, wraps PERIOD_CYCLES-1 -> 0.
  - tick = enable && counter==PERIOD_CYCLES-1.
  - enable low: counter held at 0, no tick.
- States are IDLE, SEND, DONE.
- IDLE:
  - On tick: snapshot all four data inputs into registers, byte index=0, go to SEND.
  - On the following cycle: tx_valid=1, tx_data='C', busy=1. Latency is tick cycle + 1.
- SEND, per-byte handshake:
  - A byte transfers on a cycle where tx_valid && tx_ready.
  - tx_data and tx_valid are held stable until that transfer.
  - After a transfer, the next byte is presented on the very next cycle, with no gap cycle.
  - tx_valid never deasserts without a transfer, except on reset.
- Byte order, index 0..24:
  - 0-3: 'C','H','1',':'.
  - 4: ch1 sign.
  - 5-9: digit3, '.', digit2, digit1, digit0.
  - 10-11: 'V', ' '.
  - 12-15: 'C','H','2',':'.
  - 16: ch2 sign.
  - 17-21: digit3, '.', digit2, digit1, digit0.
  - 22-24: 'V', 0x0D, 0x0A.
  - Digit n is snapshot bits [4n+3:4n].
- Digit encoding:
  - Digit value 0-9 -> 0x30+value.
  - Value 10-15 (illegal BCD) -> '?' (0x3F).
  - Sign byte other than 43/45 -> '?'.
- Overrange:
  - If snapshot bits [19:16] != 0 for a channel, that channel's four digits are sent as '9' ("9.999").
  - ovr_flag set at snapshot time; it clears only on reset.
- End of frame: when byte 24 transfers, go to DONE and tx_valid=0. DONE lasts one cycle with frame_done=1, busy still 1. Then IDLE, busy=0.
- Tick while in SEND or DONE:
  - Frame is not restarted.
  - drop_cnt increments, saturating at 255.
  - The snapshot registers do not change.
- Enable low mid-frame: the current frame completes; no new tick.
- Input changes during a frame are ignored because the frame is built from the snapshot.
- Per-frame throughput with tx_ready held high: 25 data cycles + 1 DONE cycle.

Test Plan:
- PERIOD_CYCLES=40, tx_ready=1, ch1=20'h04998 '+', ch2=20'h00012 '-' -> bytes "CH1:+4.998V CH2:-0.012V\r\n"; tx_valid high 25 consecutive cycles; frame_done pulses once one cycle after 0x0A; busy low the following cycle.
- Same setup, tx_ready toggling 1-of-3 cycles -> identical byte stream; tx_data unchanged while tx_valid=1 and tx_ready=0.
- PERIOD_CYCLES=10, tx_ready=0 for 50 cycles then 1 -> first frame completes intact; drop_cnt equals the count of ticks during busy; saturates at 255 under long stall.
- ch1=20'h10000 -> ch1 digits "9.999", ovr_flag=1 and stays set; ch2=20'h00A00 -> digit2 '?'; ch1_sig=0x00 -> sign '?'.
- Change ch1_dec at byte index 3 -> frame still shows the snapshot value; the next frame shows the new value.
- rst pulse at byte index 10 -> tx_valid, busy 0 immediately; after release, no output until the next tick (counter restarted from 0, first 'C' at cycle PERIOD_CYCLES after release); enable low -> no frames.
